// File: rtl/sc_load_scheduler.sv
// Round-robin scheduler sharing the MAROC slow-control transmitter.
// Optional load readback/verify pass: define SC_READBACK_EN.
module sc_load_scheduler #(
  parameter int N_REQ       = 4,
  parameter int SEL_W       = 2,
  parameter int TIMEOUT_CYC = 2048,
  parameter int FRAME_W     = 829,
  parameter int RB_DELAY    = 1
) (
  input  logic               clk_in,
  input  logic               reset_in,
  input  logic [N_REQ-1:0]   req_in,
  output logic [N_REQ-1:0]   grant_out,
  output logic [SEL_W-1:0]   sel_out,
  output logic [N_REQ-1:0]   done_out,
  output logic [1:0]         status_out,
  output logic               busy_out,
  output logic               start_out,
  input  logic [1:0]         tx_state_in,
  input  logic               q_sc_in,
  input  logic [FRAME_W-1:0] frame_in
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [1:0] TX_SEND  = 2'd2;
  localparam logic [1:0] TX_FINAL = 2'd3;
  localparam logic [1:0] ST_OK    = 2'd0;
  localparam logic [1:0] ST_TMO   = 2'd1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT_SEND,
    WAIT_FINAL,
    DONE
`ifdef SC_READBACK_EN
    ,
    VFY_START,
    VFY_SEND,
    VFY_FINAL
`endif
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [N_REQ-1:0] grant_q;
  logic [SEL_W-1:0] sel_q;
  logic [SEL_W-1:0] ptr_q;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       status_q;
  logic [1:0]       status_d;
  logic             pick_vld;
  logic [SEL_W-1:0] pick_idx;
  logic [SEL_W-1:0] cand;
  logic             tmo;
  logic             waiting;
  logic             mis_q;

  // Scan downward so the lowest offset from the pointer wins.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    cand     = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      cand = SEL_W'((int'(ptr_q) + i) % N_REQ);
      if (req_in[cand]) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
    end
  end

  // The cycle that would make the count TIMEOUT_CYC-1 ends the wait.
  assign tmo = (cnt_q == CNT_W'(TIMEOUT_CYC - 2));

  always_comb begin
    state_d   = state_q;
    status_d  = status_q;
    start_out = 1'b0;
    waiting   = 1'b0;
    unique case (state_q)
      IDLE: begin
        status_d = ST_OK;
        if (pick_vld) state_d = START;
      end
      START: begin
        start_out = 1'b1;
        state_d   = WAIT_SEND;
      end
      WAIT_SEND: begin
        waiting = 1'b1;
        if (tx_state_in == TX_SEND) begin
          state_d = WAIT_FINAL;
        end else if (tmo) begin
          state_d  = DONE;
          status_d = ST_TMO;
        end
      end
      WAIT_FINAL: begin
        waiting = 1'b1;
        if (tx_state_in == TX_FINAL) begin
`ifdef SC_READBACK_EN
          state_d = VFY_START;
`else
          state_d  = DONE;
          status_d = ST_OK;
`endif
        end else if (tmo) begin
          state_d  = DONE;
          status_d = ST_TMO;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
`ifdef SC_READBACK_EN
      VFY_START: begin
        start_out = 1'b1;
        state_d   = VFY_SEND;
      end
      VFY_SEND: begin
        waiting = 1'b1;
        if (tx_state_in == TX_SEND) begin
          state_d = VFY_FINAL;
        end else if (tmo) begin
          state_d  = DONE;
          status_d = ST_TMO;
        end
      end
      VFY_FINAL: begin
        waiting = 1'b1;
        if (tx_state_in == TX_FINAL) begin
          state_d  = DONE;
          status_d = mis_q ? 2'd2 : ST_OK;
        end else if (tmo) begin
          state_d  = DONE;
          status_d = ST_TMO;
        end
      end
`endif
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      sel_q    <= '0;
      ptr_q    <= '0;
      cnt_q    <= '0;
      status_q <= ST_OK;
    end else begin
      state_q  <= state_d;
      status_q <= status_d;
      if (state_q == IDLE && pick_vld) begin
        grant_q <= N_REQ'(1) << pick_idx;
        sel_q   <= pick_idx;
      end
      // sel_q is left alone so the mux holds past done.
      if (state_q == DONE) begin
        grant_q <= '0;
        if (sel_q == SEL_W'(N_REQ - 1)) ptr_q <= '0;
        else ptr_q <= sel_q + 1'b1;
      end
      if (start_out) cnt_q <= '0;
      else if (waiting) cnt_q <= cnt_q + 1'b1;
    end
  end

`ifdef SC_READBACK_EN
  localparam int POS_W = $clog2(FRAME_W + RB_DELAY + 1) + 1;
  localparam int K_W   = $clog2(FRAME_W);

  logic [POS_W-1:0] pos_q;
  logic [POS_W-1:0] k_full;
  logic             rb_act;

  // pos_q counts cycles since SENDING was first seen in the verify load.
  assign k_full = pos_q - POS_W'(RB_DELAY);
  assign rb_act = (state_q == VFY_FINAL) &&
                  (pos_q >= POS_W'(RB_DELAY)) &&
                  (k_full < POS_W'(FRAME_W));

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      pos_q <= '0;
      mis_q <= 1'b0;
    end else if (state_q == VFY_START) begin
      pos_q <= '0;
      mis_q <= 1'b0;
    end else if (state_q == VFY_SEND) begin
      if (tx_state_in == TX_SEND) begin
        pos_q <= POS_W'(1);
        if (RB_DELAY == 0 && q_sc_in != frame_in[0]) mis_q <= 1'b1;
      end
    end else if (state_q == VFY_FINAL) begin
      if (pos_q != '1) pos_q <= pos_q + 1'b1;
      if (rb_act && q_sc_in != frame_in[k_full[K_W-1:0]]) mis_q <= 1'b1;
    end
  end
`else
  logic unused_rb;
  assign mis_q     = 1'b0;
  assign unused_rb = ^{q_sc_in, frame_in, mis_q} ^ RB_DELAY[0];
`endif

  assign grant_out  = grant_q;
  assign sel_out    = sel_q;
  assign busy_out   = (state_q != IDLE);
  assign done_out   = (state_q == DONE) ? grant_q : '0;
  assign status_out = (state_q == DONE) ? status_q : ST_OK;

endmodule

// File: tb/tb_sc_load_scheduler.sv
// Directed bench for sc_load_scheduler with a simple transmitter model.
// Build with SC_READBACK_EN to exercise the verify pass.
module tb_sc_load_scheduler;

  localparam int N_REQ = 4;
  localparam int SEL_W = 2;
  localparam int TMO   = 2048;
  localparam int FW    = 829;
  localparam int RBD   = 1;
  localparam int BOUND = 6000;
`ifdef SC_READBACK_EN
  localparam int N_START = 2;
`else
  localparam int N_START = 1;
`endif

  logic             clk_in = 1'b0;
  logic             reset_in;
  logic [N_REQ-1:0] req_in;
  logic [N_REQ-1:0] grant_out;
  logic [SEL_W-1:0] sel_out;
  logic [N_REQ-1:0] done_out;
  logic [1:0]       status_out;
  logic             busy_out;
  logic             start_out;
  logic [1:0]       tx_state;
  logic             q_sc_in;
  logic [FW-1:0]    frame_in;

  sc_load_scheduler #(
    .N_REQ(N_REQ), .SEL_W(SEL_W), .TIMEOUT_CYC(TMO),
    .FRAME_W(FW), .RB_DELAY(RBD)
  ) dut (
    .clk_in(clk_in), .reset_in(reset_in), .req_in(req_in),
    .grant_out(grant_out), .sel_out(sel_out),
    .done_out(done_out), .status_out(status_out),
    .busy_out(busy_out), .start_out(start_out),
    .tx_state_in(tx_state), .q_sc_in(q_sc_in),
    .frame_in(frame_in)
  );

  always #5 clk_in = ~clk_in;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  bit stuck;
  bit flip_en;
  int flip_idx;
  int tx_cnt;

  int starts = 0;
  int dones = 0;
  int start_q[$];
  logic [N_REQ-1:0] done_val;
  logic [1:0] done_stat;
  logic [SEL_W-1:0] done_sel;
  int done_cyc;

  // Transmitter: PREPARE 1 cycle, SENDING 830 cycles, then FINAL.
  always @(posedge clk_in) begin
    cyc <= cyc + 1;
    if (reset_in) begin
      tx_state <= 2'd0;
      tx_cnt   <= 0;
    end else if (start_out) begin
      tx_state <= 2'd1;
      tx_cnt   <= 0;
    end else begin
      case (tx_state)
        2'd1: if (!stuck) begin
          tx_state <= 2'd2;
          tx_cnt   <= 0;
        end
        2'd2: begin
          if (tx_cnt == FW) tx_state <= 2'd3;
          tx_cnt <= tx_cnt + 1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    q_sc_in = 1'b0;
    if (tx_state == 2'd2 && tx_cnt >= RBD && tx_cnt - RBD < FW)
      q_sc_in = frame_in[tx_cnt - RBD] ^
                (flip_en && (tx_cnt - RBD == flip_idx));
  end

  always @(negedge clk_in) begin
    if (start_out) begin
      starts++;
      start_q.push_back(cyc);
    end
    if (done_out != '0) begin
      dones++;
      done_val  = done_out;
      done_stat = status_out;
      done_sel  = sel_out;
      done_cyc  = cyc;
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic wait_done(input int d0);
    int k;
    k = 0;
    while (dones == d0 && k < BOUND) begin
      @(negedge clk_in);
      k++;
    end
  endtask

  task automatic wait_grant();
    int k;
    k = 0;
    while (grant_out == '0 && k < 10) begin
      @(negedge clk_in);
      k++;
    end
  endtask

  typedef struct {
    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] grant;
    logic [SEL_W-1:0] sel;
    logic [1:0]       status;
    bit               stuck;
  } vec_t;

  vec_t vecs[6];

  task automatic run_txn(input vec_t v);
    int s0;
    int d0;
    s0 = starts;
    d0 = dones;
    stuck = v.stuck;
    req_in = v.req;
    wait_grant();
    chk("grant", int'(grant_out), int'(v.grant));
    chk("sel", int'(sel_out), int'(v.sel));
    chk("busy", int'(busy_out), 1);
    wait_done(d0);
    chk("done_seen", dones - d0, 1);
    chk("done_val", int'(done_val), int'(v.grant));
    chk("done_sel", int'(done_sel), int'(v.sel));
    chk("status", int'(done_stat), int'(v.status));
    chk("starts", starts - s0, v.stuck ? 1 : N_START);
    if (v.stuck && start_q.size() > s0)
      chk("tmo_cyc", done_cyc - start_q[s0], TMO);
    req_in = '0;
    stuck = 1'b0;
    @(negedge clk_in);
    chk("post_busy", int'(busy_out), 0);
    chk("post_grant", int'(grant_out), 0);
  endtask

  initial begin
    int d0;
    int k;
    vecs[0] = '{4'b0001, 4'b0001, 2'd0, 2'd0, 1'b0};
    vecs[1] = '{4'b1001, 4'b1000, 2'd3, 2'd0, 1'b0};
    vecs[2] = '{4'b0110, 4'b0010, 2'd1, 2'd0, 1'b0};
    vecs[3] = '{4'b0011, 4'b0001, 2'd0, 2'd0, 1'b0};
    vecs[4] = '{4'b0100, 4'b0100, 2'd2, 2'd1, 1'b1};
    vecs[5] = '{4'b1000, 4'b1000, 2'd3, 2'd0, 1'b0};

    reset_in = 1'b1;
    req_in   = '0;
    stuck    = 1'b0;
    flip_en  = 1'b0;
    flip_idx = 500;
    frame_in = FW'(1);
    repeat (3) @(negedge clk_in);
    reset_in = 1'b0;
    chk("rst_grant", int'(grant_out), 0);
    chk("rst_busy", int'(busy_out), 0);
    chk("rst_start", int'(start_out), 0);
    chk("rst_done", int'(done_out), 0);

    // Reset during WAIT_FINAL aborts silently.
    req_in = 4'b0010;
    wait_grant();
    chk("mid_grant", int'(grant_out), 4'b0010);
    k = 0;
    while (tx_state != 2'd2 && k < 20) begin
      @(negedge clk_in);
      k++;
    end
    repeat (5) @(negedge clk_in);
    chk("mid_busy", int'(busy_out), 1);
    d0 = dones;
    reset_in = 1'b1;
    req_in = '0;
    repeat (3) @(negedge clk_in);
    reset_in = 1'b0;
    chk("mr_outs", int'({grant_out, sel_out, done_out,
                         status_out, busy_out, start_out}), 0);
    repeat (50) @(negedge clk_in);
    chk("mr_nodone", dones - d0, 0);
    chk("mr_idle", int'(busy_out), 0);

    for (int i = 0; i < 6; i++) run_txn(vecs[i]);

    // All four request together; each drops after its done.
    req_in = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      d0 = dones;
      wait_done(d0);
      chk("rr_done", int'(done_val), 1 << i);
      req_in[i] = 1'b0;
      if (i == 3) req_in[0] = 1'b1;
    end
    @(negedge clk_in);
    wait_grant();
    chk("rr_wrap", int'(grant_out), 4'b0001);
    d0 = dones;
    wait_done(d0);
    req_in = '0;
    chk("rr_wrap_done", int'(done_val), 4'b0001);

    // Requester 2 comes and goes while another load is busy.
    @(negedge clk_in);
    req_in = 4'b0001;
    wait_grant();
    repeat (20) @(negedge clk_in);
    req_in = 4'b0101;
    repeat (100) @(negedge clk_in);
    req_in = 4'b0001;
    d0 = dones;
    wait_done(d0);
    req_in = '0;
    chk("drop_done", int'(done_val), 4'b0001);
    d0 = starts;
    k = 0;
    repeat (20) begin
      @(negedge clk_in);
      if (busy_out || grant_out != '0) k++;
    end
    chk("drop_nobusy", k, 0);
    chk("drop_nostart", starts - d0, 0);

`ifdef SC_READBACK_EN
    flip_en = 1'b1;
    run_txn('{4'b0010, 4'b0010, 2'd1, 2'd2, 1'b0});
    flip_en = 1'b0;
    run_txn('{4'b0100, 4'b0100, 2'd2, 2'd0, 1'b0});
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sc_load_scheduler.md
Name: sc_load_scheduler

Overview:
Controller that shares the single MAROC slow-control serial transmitter between N_REQ configuration requesters, such as the host register bank, the power-up default loader and the calibration sequencer.
- Arbitrates requests round-robin.
- Drives the selected requester index to the external frame mux.
- Issues a one-cycle start to the transmitter and tracks its 2-bit state until the frame is fully shifted.
- Reports per-requester completion with status.
- Guards every load with a timeout.

Parameters:
N_REQ, 4, number of requesters (2..8)
SEL_W, 2, width of sel_out (ceil log2 N_REQ, min 1)
TIMEOUT_CYC, 2048, max cycles allowed from start pulse to transmitter FINAL
FRAME_W, 829, slow-control frame length in bits (readback only)
RB_DELAY, 1, cycles between transmitter entering SENDING and first valid q_sc_in bit (readback only)

Ports:
clk_in  in  1  slow-control clock (5 MHz); sole clock
reset_in  in  1  synchronous, active-high reset
req_in  in  N_REQ  level request per requester
grant_out  out  N_REQ  one-hot grant, held for the whole transaction
sel_out  out  SEL_W  index of granted requester (frame mux select)
done_out  out  N_REQ  one-cycle completion pulse to granted requester
status_out  out  2  valid with done_out: 0 ok, 1 timeout, 2 readback mismatch
busy_out  out  1  high in every state except IDLE
start_out  out  1  one-cycle start to transmitter start_in
tx_state_in  in  2  transmitter state: 0 IDLE, 1 PREPARE, 2 SENDING, 3 FINAL
q_sc_in  in  1  MAROC serial readback (SC_READBACK_EN only)
frame_in  in  FRAME_W  muxed frame being loaded (SC_READBACK_EN only)

Behaviour:
- Reset (sync, reset_in high at clk_in edge):
  - Outputs: grant_out=0, sel_out=0, done_out=0, status_out=0, busy_out=0, start_out=0.
  - Internal: RR pointer=0, timeout counter=0, state IDLE.
  - Reset mid-transaction aborts without a done pulse. The transmitter is reset by the same reset_in.
- FSM states:
  - IDLE: if any req_in is set, pick the first set bit searching from the RR pointer upward (wrapping). Register grant_out and sel_out, go to START. The grant is visible 1 cycle after req is sampled.
  - START: start_out=1 for exactly this one cycle, clear timeout counter, go to WAIT_SEND.
  - WAIT_SEND: wait for tx_state_in==2, then go to WAIT_FINAL.
  - WAIT_FINAL: wait for tx_state_in==3, then go to DONE (or to VERIFY_START when the feature is enabled).
  - DONE:
    - Pulse done_out[granted]=1 for 1 cycle with status_out.
    - Clear grant_out.
    - Set RR pointer = granted+1 mod N_REQ.
    - Return to IDLE.
- Timeout:
  - The counter increments each cycle in WAIT_SEND and WAIT_FINAL.
  - On reaching TIMEOUT_CYC-1 without the awaited state, go to DONE with status=1.
  - No retry is performed.
- Requester contract:
  - The requester must drop req_in in the cycle after done_out.
  - If req is still high in IDLE, it is re-arbitrated normally, i.e. it takes the lowest priority after its own grant.
- Requests that deassert before grant are ignored. Changes to req_in while busy have no effect.
- sel_out is stable from the grant until the cycle after done_out. The frame mux therefore holds during the start_out cycle, in which the transmitter latches the frame.
- Minimum transaction: grant, START, then a transmitter run of about FRAME_W+2 cycles, then DONE.

Optional Feature:
Macro: SC_READBACK_EN.
- Defined:
  - After the first load reaches FINAL, the scheduler issues a second start pulse (VERIFY_START) for the same frame.
  - MAROC shifts its previous contents out on q_sc_in during the second load.
  - Bit counter k starts at 0, RB_DELAY cycles after tx_state_in first reads 2 in the second load.
  - Each cycle, compare q_sc_in with frame_in[k] for k=0..FRAME_W-1; the sticky mismatch flag is set on any difference.
  - On FINAL, go to DONE with status=2 if the flag is set, else 0.
  - The timeout applies to the second load too, and timeout takes precedence over mismatch.
- Undefined: q_sc_in and frame_in are ignored (left unconnected), the VERIFY states do not exist, and status 2 is never produced.

Test Plan:
1. Reset held 3 cycles mid-WAIT_FINAL (grant_out=0010) -> next cycle all outputs 0, state IDLE, no done pulse.
2. req_in=0001 with transmitter model (PREPARE 1 cycle, SENDING 830 cycles) -> grant_out=0001, start_out high exactly 1 cycle, done_out=0001 with status 0, busy_out low after DONE.
3. req_in=1111 held continuously, each requester dropping req after its done -> grants in order 0,1,2,3; simultaneous re-request of 0 after 3 -> grant 0.
4. Transmitter model stuck at tx_state 1, TIMEOUT_CYC=2048 -> done_out pulses 2048 cycles after start with status_out=1.
5. SC_READBACK_EN, frame_in=829'h1, model returns identical stream -> two start pulses, status 0; flip bit 500 of returned stream -> status 2.
6. Requester 2 releases req_in one cycle before grant, others idle -> no grant, busy_out stays 0.
